wb_line_biu: RTL and testbench
==============================

# wb_line_biu

Parametrised Wishbone B3 burst bus-interface unit between the I-cache/D-cache refill logic and the system Wishbone bus. It accepts one full-line read (refill) or write (writeback) request, runs a registered-feedback burst of `LINE_WORDS` beats, and assembles or serialises the line. It then returns one response pulse carrying the line-ordered data and an error flag. It generalises the fixed 8×32-bit refill unit with configurable width and depth, writeback, bounded retry and optional critical-word-first wrap bursts.

## Interface
- `DW`, 32, Wishbone data width; multiple of 8.
- `AW`, 32, Wishbone address width.
- `LINE_WORDS`, 8, beats per line; 4, 8 or 16.
- `RETRY_MAX`, 3, number of `wb_rty_i` restarts allowed before reporting an error; 0..15.

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  line request valid.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_we`  in  1  1 = writeback, 0 = refill.
- `req_adr`  in  AW  byte address of the critical word.
- `req_wdata`  in  DW*LINE_WORDS  writeback line; word i is at `[DW*i +: DW]`.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  qualified by `rsp_valid`.
- `rsp_rdata`  out  DW*LINE_WORDS  refill line, line-ordered, held until the next accepted refill.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each.
- `wb_adr_o`  out  AW.
- `wb_sel_o`  out  DW/8.
- `wb_dat_o`  out  DW.
- `wb_cti_o`  out  3.
- `wb_bte_o`  out  2.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1 each.
- `wb_dat_i`  in  DW.

## Operation
- Derived constants:
  - `OB = log2(DW/8)`.
  - `IB = log2(LINE_WORDS)`.
  - Word index = `adr[OB+IB-1:OB]`.
- States: IDLE, BURST, BACKOFF, RESP.
- IDLE → BURST on accept. The unit latches:
  - `req_we` and `req_wdata`;
  - the line base (`req_adr` with the low `OB+IB` bits cleared);
  - the start index;
  - beat counter = 0 and retry counter = 0.
- BURST: `cyc`/`stb` are high and `sel` is all ones.
  - `wb_adr_o` = base | (index << OB).
  - `wb_dat_o` = latched word[index].
  - `wb_cti_o` = 3'b010 for beats 0..LINE_WORDS-2 and 3'b111 on the last beat.
- On `wb_ack_i` with `stb`:
  - a refill stores `wb_dat_i` into `rsp_rdata` word[index];
  - the index advances (see Configuration) and the beat counter increments.
- Last-beat ack → RESP.
- `wb_err_i` → RESP with error set. On a refill, the `rsp_rdata` contents are undefined.
- `wb_rty_i`:
  - if retry count < `RETRY_MAX`: increment the retry count and go to BACKOFF;
  - otherwise → RESP with error set.
- BACKOFF: `cyc`/`stb` are low for exactly one cycle. The unit then re-enters BURST from beat 0 at the original start index, so the whole line is reissued.
- RESP: `rsp_valid` = 1 for one cycle, then IDLE.
- Simultaneous termination inputs: priority is err > rty > ack.
- Any termination input while `stb` is low is ignored.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `cyc`, `stb`, `we` = 0.
  - `adr` = 0, `dat_o` = 0, `rsp_rdata` = 0.
  - `sel` = all ones, `cti` = 3'b111, `bte` = 2'b00.
- All outputs are registered.
- `cyc`/`stb` assert on the edge that accepts the request, i.e. in the cycle after `req_valid & req_ready`.
- With zero-wait-state ack, `LINE_WORDS` beats take `LINE_WORDS` cycles.
- `cyc`/`stb` drop on the edge that samples the final ack. `rsp_valid` rises on that same edge.
- Request-to-`rsp_valid` latency is therefore `LINE_WORDS`+1 cycles at minimum.
- `req_ready` is 0 from acceptance until IDLE is re-entered; the next request can be accepted the cycle after `rsp_valid`.
- Wait states: `stb` held with no ack keeps address, data and `cti` stable.
- Reset asserted mid-burst forces all outputs to their reset values immediately; no response is issued.

## Configuration
- `WB_BIU_WRAP_EN` defined — critical-word-first:
  - start index = `req_adr` word index;
  - index increments modulo `LINE_WORDS`;
  - `wb_bte_o` = 2'b01 / 2'b10 / 2'b11 for 4 / 8 / 16 beats, driven during BURST.
- Undefined — linear:
  - start index = 0;
  - index increments from 0 to LINE_WORDS-1;
  - `wb_bte_o` = 2'b00.
- In both modes `rsp_rdata` is line-ordered.

## Test plan
- Refill, LINE_WORDS=8, DW=32, `req_adr`=0x1000, zero-wait ack, `wb_dat_i`=0xA0+beat → 8 beats at adr 0x1000..0x101C; `cti` is 010×7 then 111; `rsp_rdata` word i = 0xA0+i; `rsp_valid` 9 cycles after acceptance with `rsp_err`=0.
- Writeback with `req_wdata` word i = 0x100+i and one wait state per beat → each adr/`dat_o` pair is held 2 cycles; `we`=1 throughout; 17-cycle latency.
- `WB_BIU_WRAP_EN`, refill at `req_adr`=0x2014 → address order 0x2014, 0x2018, 0x201C, 0x2000 … 0x2010; `bte`=10; `rsp_rdata` is line-ordered.
- `wb_rty_i` on beat 3 with `RETRY_MAX`=1 → 1-cycle `cyc` gap, restart at beat 0, success with `rsp_err`=0. A second rty in the same request → `rsp_err`=1.
- `wb_err_i` and `wb_ack_i` together on beat 5 → `cyc` drops; `rsp_valid`=1 with `rsp_err`=1.
- `wb_rst_i` pulsed at beat 4 → `cyc`/`stb` = 0 immediately; no `rsp_valid`; `req_ready`=1; a new request then completes normally.

Source files
------------

// File: rtl/wb_line_biu.sv
// Wishbone B3 burst BIU: refills or writes back one cache line per request.
// Ports: req_* line request, rsp_* completion, wb_* system bus master.
// Optional WB_BIU_WRAP_EN: critical-word-first wrap bursts (default linear).
module wb_line_biu #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int LINE_WORDS = 8,
  parameter int RETRY_MAX  = 3
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [AW-1:0]            req_adr,
  input  logic [DW*LINE_WORDS-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [DW*LINE_WORDS-1:0] rsp_rdata,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [AW-1:0]            wb_adr_o,
  output logic [DW/8-1:0]          wb_sel_o,
  output logic [DW-1:0]            wb_dat_o,
  output logic [2:0]               wb_cti_o,
  output logic [1:0]               wb_bte_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic [DW-1:0]            wb_dat_i
);

  localparam int OB = $clog2(DW/8);
  localparam int IB = $clog2(LINE_WORDS);
  localparam int LB = DW*LINE_WORDS;
  localparam logic [AW-1:0] BASE_MASK = {AW{1'b1}} << (OB+IB);
  localparam logic [IB-1:0] LAST = IB'(LINE_WORDS-1);
  localparam logic [3:0]    RMAX = 4'(RETRY_MAX);
  localparam logic [2:0]    CTI_INC = 3'b010;
  localparam logic [2:0]    CTI_EOB = 3'b111;

`ifdef WB_BIU_WRAP_EN
  localparam logic [1:0] BTE_B = (LINE_WORDS == 4) ? 2'b01 :
                                 (LINE_WORDS == 8) ? 2'b10 : 2'b11;
  logic [IB-1:0] w_req_start;
  assign w_req_start = req_adr[OB+IB-1:OB];
`else
  localparam logic [1:0] BTE_B = 2'b00;
  logic [IB-1:0] w_req_start;
  assign w_req_start = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_BURST, S_BACKOFF, S_RESP
  } state_t;

  state_t        r_state, w_state;
  logic          r_we, w_we;
  logic [LB-1:0] r_wdata, w_wdata;
  logic [AW-1:0] r_base, w_base;
  logic [IB-1:0] r_start, w_start;
  logic [IB-1:0] r_idx, w_idx;
  logic [IB-1:0] r_beat, w_beat;
  logic [3:0]    r_rty, w_rty;

  logic          w_ready, w_rsp_valid, w_rsp_err;
  logic [LB-1:0] w_rdata;
  logic          w_cyc, w_stb, w_we_o;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dat;
  logic [2:0]    w_cti;
  logic [1:0]    w_bte;
  logic          w_load, w_stop;

  always_comb begin
    w_state     = r_state;
    w_we        = r_we;
    w_wdata     = r_wdata;
    w_base      = r_base;
    w_start     = r_start;
    w_idx       = r_idx;
    w_beat      = r_beat;
    w_rty       = r_rty;
    w_ready     = req_ready;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rdata     = rsp_rdata;
    w_cyc       = wb_cyc_o;
    w_stb       = wb_stb_o;
    w_we_o      = wb_we_o;
    w_cti       = wb_cti_o;
    w_bte       = wb_bte_o;
    w_load      = 1'b0;
    w_stop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state = S_BURST;
          w_we    = req_we;
          w_wdata = req_wdata;
          w_base  = req_adr & BASE_MASK;
          w_start = w_req_start;
          w_rty   = '0;
          w_ready = 1'b0;
          w_load  = 1'b1;
        end
      end
      S_BURST: begin
        if (wb_stb_o) begin
          if (wb_err_i) begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            w_stop      = 1'b1;
          end else if (wb_rty_i) begin
            w_stop = 1'b1;
            if (r_rty < RMAX) begin
              w_rty   = r_rty + 4'd1;
              w_state = S_BACKOFF;
            end else begin
              w_state     = S_RESP;
              w_rsp_valid = 1'b1;
              w_rsp_err   = 1'b1;
            end
          end else if (wb_ack_i) begin
            if (!r_we) w_rdata[DW*r_idx +: DW] = wb_dat_i;
            if (r_beat == LAST) begin
              w_state     = S_RESP;
              w_rsp_valid = 1'b1;
              w_stop      = 1'b1;
            end else begin
              // index wraps naturally modulo LINE_WORDS
              w_idx  = r_idx + 1'b1;
              w_beat = r_beat + 1'b1;
              w_cti  = (w_beat == LAST) ? CTI_EOB : CTI_INC;
            end
          end
        end
      end
      S_BACKOFF: begin
        w_state = S_BURST;
        w_load  = 1'b1;
      end
      S_RESP: begin
        w_state = S_IDLE;
        w_ready = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    // (re)start the line at its original start index
    if (w_load) begin
      w_idx  = w_start;
      w_beat = '0;
      w_cyc  = 1'b1;
      w_stb  = 1'b1;
      w_we_o = w_we;
      w_cti  = CTI_INC;
      w_bte  = BTE_B;
    end
    if (w_stop) begin
      w_cyc  = 1'b0;
      w_stb  = 1'b0;
      w_we_o = 1'b0;
      w_cti  = CTI_EOB;
      w_bte  = 2'b00;
    end
    w_adr = w_base | (AW'(w_idx) << OB);
    w_dat = w_wdata[DW*w_idx +: DW];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_base    <= '0;
      r_start   <= '0;
      r_idx     <= '0;
      r_beat    <= '0;
      r_rty     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '1;
      wb_dat_o  <= '0;
      wb_cti_o  <= CTI_EOB;
      wb_bte_o  <= 2'b00;
    end else begin
      r_state   <= w_state;
      r_we      <= w_we;
      r_wdata   <= w_wdata;
      r_base    <= w_base;
      r_start   <= w_start;
      r_idx     <= w_idx;
      r_beat    <= w_beat;
      r_rty     <= w_rty;
      req_ready <= w_ready;
      rsp_valid <= w_rsp_valid;
      rsp_err   <= w_rsp_err;
      rsp_rdata <= w_rdata;
      wb_cyc_o  <= w_cyc;
      wb_stb_o  <= w_stb;
      wb_we_o   <= w_we_o;
      wb_adr_o  <= w_adr;
      wb_sel_o  <= '1;
      wb_dat_o  <= w_dat;
      wb_cti_o  <= w_cti;
      wb_bte_o  <= w_bte;
    end
  end

endmodule

// File: tb/tb_wb_line_biu.sv
// Directed table-driven bench for wb_line_biu (DW=32, 8 beats, RETRY_MAX=1).
// A small Wishbone slave model answers beats and checks every bus cycle.
module tb_wb_line_biu;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 8;
`ifdef WB_BIU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we;
  logic [AW-1:0]    req_adr;
  logic [DW*LW-1:0] req_wdata;
  logic             rsp_valid, rsp_err;
  logic [DW*LW-1:0] rsp_rdata;
  logic             cyc, stb, we;
  logic [AW-1:0]    adr;
  logic [3:0]       sel;
  logic [DW-1:0]    dat_o, dat_i;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack, err, rty;

  always #5 clk = ~clk;

  wb_line_biu #(
    .DW(DW), .AW(AW), .LINE_WORDS(LW), .RETRY_MAX(1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_adr_o(adr), .wb_sel_o(sel), .wb_dat_o(dat_o),
    .wb_cti_o(cti), .wb_bte_o(bte),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
    .wb_dat_i(dat_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    int          waits;
    int          rty_beat;
    int          rty_n;
    int          err_beat;
    logic        exp_err;
    int          exp_lat;
    int          exp_gaps;
    logic        junk;
  } vec_t;

  vec_t vecs[8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int b, w, rd, n, gaps, idx, start;
    bit done;
    logic [31:0] base;
    b = 0; w = 0; rd = 0; n = 0; gaps = 0; done = 0;
    base  = v.adr & 32'hFFFF_FFE0;
    start = WRAP ? int'((v.adr >> 2) & 32'h7) : 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_adr   = v.adr;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (rsp_valid) begin
        done = 1;
        chk("latency", 32'(n), 32'(v.exp_lat));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("cyc_gaps", 32'(gaps), 32'(v.exp_gaps));
        chk("rsp_ready", 32'(req_ready), 32'd0);
        if (!v.we && !v.exp_err)
          for (int i = 0; i < LW; i++)
            chk("rdata", rsp_rdata[32*i +: 32], 32'(32'hA0 + i));
      end else if (!cyc) begin
        gaps++;
        chk("gap_stb", 32'(stb), 32'd0);
        ack = v.junk;
      end else begin
        idx = (start + b) % LW;
        chk("adr", adr, 32'(base + 32'(4*idx)));
        chk("dat_o", dat_o, 32'(32'h100 + idx));
        chk("cti", 32'(cti), (b == LW-1) ? 32'd7 : 32'd2);
        chk("bte", 32'(bte), WRAP ? 32'd2 : 32'd0);
        chk("we", 32'(we), 32'(v.we));
        chk("stb", 32'(stb), 32'd1);
        chk("sel", 32'(sel), 32'hF);
        chk("busy_ready", 32'(req_ready), 32'd0);
        if (w < v.waits) begin
          w++;
        end else begin
          w = 0;
          if (b == v.rty_beat && rd < v.rty_n) begin
            rty = 1'b1; rd++; b = 0;
          end else if (b == v.err_beat) begin
            err = 1'b1; ack = 1'b1;
          end else begin
            ack = 1'b1; dat_i = 32'(32'hA0 + idx); b++;
          end
        end
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no rsp_valid after %0d cycles", n);
    end else begin
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    // we adr waits rty_beat rty_n err_beat exp_err lat gaps junk
    vecs[0] = '{1'b0, 32'h1000, 0, -1, 0, -1, 1'b0,  9, 0, 1'b0};
    vecs[1] = '{1'b1, 32'h1000, 1, -1, 0, -1, 1'b0, 17, 0, 1'b0};
    vecs[2] = '{1'b0, 32'h2014, 0, -1, 0, -1, 1'b0,  9, 0, 1'b0};
    vecs[3] = '{1'b0, 32'h1000, 0,  3, 1, -1, 1'b0, 14, 1, 1'b1};
    vecs[4] = '{1'b0, 32'h1000, 0,  3, 2, -1, 1'b1, 10, 1, 1'b0};
    vecs[5] = '{1'b0, 32'h1000, 0, -1, 0,  5, 1'b1,  7, 0, 1'b0};
    vecs[6] = '{1'b1, 32'h3000, 2, -1, 0,  0, 1'b1,  4, 0, 1'b0};
    vecs[7] = '{1'b1, 32'h3004, 0,  7, 1, -1, 1'b0, 18, 1, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0;
    ack = 1'b0; err = 1'b0; rty = 1'b0; dat_i = '0;
    for (int i = 0; i < LW; i++)
      req_wdata[32*i +: 32] = 32'(32'h100 + i);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rdata", 32'(|rsp_rdata), 32'd0);
    chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_cti", 32'(cti), 32'd7);
    chk("rst_bte", 32'(bte), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run(vecs[k]);

    // reset pulse while beat 4 is on the bus
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      ack = 1'b1;
      dat_i = 32'(32'hA0 + k);
    end
    @(negedge clk);
    ack = 1'b0;
    chk("mid_adr", adr, 32'h1010);
    chk("mid_cyc", 32'(cyc), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_cyc", 32'(cyc), 32'd0);
    chk("arst_stb", 32'(stb), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_rsp", 32'(rsp_valid), 32'd0);
    chk("arst_adr", adr, 32'd0);
    chk("arst_cti", 32'(cti), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_cyc", 32'(cyc), 32'd0);
    end
    run(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
